// File: rtl/frog_game_ctrl_if.sv
// Button/collision inputs and frog status outputs of the game sequencer.
// master: the side that drives buttons and consumes status (board / bench).
// slave:  the game sequencer itself.
interface frog_game_ctrl_if;
  logic       i_Start;
  logic       i_Frog_Up;
  logic       i_Frog_Dn;
  logic       i_Frog_Lt;
  logic       i_Frog_Rt;
  logic       i_Collide;
  logic [9:0] o_Frog_X;
  logic [9:0] o_Frog_Y;
  logic       o_Draw_Frog;
  logic [2:0] o_State;
  logic [1:0] o_Lives;
  logic [7:0] o_Score;
  logic       o_Hop;

  modport master (
    output i_Start, i_Frog_Up, i_Frog_Dn, i_Frog_Lt, i_Frog_Rt, i_Collide,
    input  o_Frog_X, o_Frog_Y, o_Draw_Frog, o_State, o_Lives, o_Score, o_Hop
  );

  modport slave (
    input  i_Start, i_Frog_Up, i_Frog_Dn, i_Frog_Lt, i_Frog_Rt, i_Collide,
    output o_Frog_X, o_Frog_Y, o_Draw_Frog, o_State, o_Lives, o_Score, o_Hop
  );
endinterface

// File: rtl/frog_game_ctrl.sv
// Frog game sequencer: owns the frog position, turns button presses into hops
// with a cooldown, handles collision death/respawn, lives, scoring and
// start/game-over control. All outputs are registered.
module frog_game_ctrl #(
  parameter int unsigned TILE_SIZE      = 32,
  parameter int unsigned H_VISIBLE_AREA = 640,
  parameter int unsigned V_VISIBLE_AREA = 480,
  parameter int unsigned X_BASE         = 320,
  parameter int unsigned Y_BASE         = 448,
  parameter int unsigned HOP_CYCLES     = 2500000,
  parameter int unsigned DEATH_CYCLES   = 12500000,
  parameter int unsigned LIVES          = 3
) (
  input logic             i_Clk,
  input logic             i_Rst,
  frog_game_ctrl_if.slave bus
);

  localparam int unsigned HopW   = ($clog2(HOP_CYCLES) > 1) ? $clog2(HOP_CYCLES) : 1;
  // At least 4 bits so the blink bit (bit 3) always exists.
  localparam int unsigned DeathW = ($clog2(DEATH_CYCLES) > 4) ? $clog2(DEATH_CYCLES) : 4;

  localparam logic [10:0] Tile   = 11'(TILE_SIZE);
  localparam logic [10:0] XMax   = 11'(H_VISIBLE_AREA - TILE_SIZE);
  localparam logic [10:0] YMax   = 11'(V_VISIBLE_AREA - TILE_SIZE);
  localparam logic [9:0]  XBase  = 10'(X_BASE);
  localparam logic [9:0]  YBase  = 10'(Y_BASE);
  localparam logic [9:0]  Step   = 10'(TILE_SIZE);
  localparam logic [1:0]  LivesInit = 2'(LIVES);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StPlay     = 3'd1,
    StHop      = 3'd2,
    StDead     = 3'd3,
    StGameOver = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [9:0]          frog_x_q, frog_x_d;
  logic [9:0]          frog_y_q, frog_y_d;
  logic [1:0]          lives_q, lives_d;
  logic [7:0]          score_q, score_d;
  logic                hop_q, hop_d;
  logic                draw_q, draw_d;
  logic [HopW-1:0]     hop_cnt_q, hop_cnt_d;
  logic [DeathW-1:0]   death_cnt_q, death_cnt_d;

  logic [10:0] x_w, y_w;
  logic        one_hot, up_ok, dn_ok, lt_ok, rt_ok, move_ok, goal;
  logic        hop_done, death_done;

  // Move decode in 11 bits so the bound checks cannot wrap.
  assign x_w     = {1'b0, frog_x_q};
  assign y_w     = {1'b0, frog_y_q};
  assign one_hot = $onehot({bus.i_Frog_Up, bus.i_Frog_Dn, bus.i_Frog_Lt, bus.i_Frog_Rt});
  assign up_ok   = bus.i_Frog_Up && (y_w >= Tile);
  assign dn_ok   = bus.i_Frog_Dn && ((y_w + Tile) <= YMax);
  assign lt_ok   = bus.i_Frog_Lt && (x_w >= Tile);
  assign rt_ok   = bus.i_Frog_Rt && ((x_w + Tile) <= XMax);
  assign move_ok = one_hot && (up_ok || dn_ok || lt_ok || rt_ok);
  // An up hop landing on row 0 reaches the goal.
  assign goal    = up_ok && (y_w == Tile);

  assign hop_done   = (hop_cnt_q == HopW'(HOP_CYCLES - 1));
  assign death_done = (death_cnt_q == DeathW'(DEATH_CYCLES - 1));

  // State and datapath registers.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q     <= StIdle;
      frog_x_q    <= XBase;
      frog_y_q    <= YBase;
      lives_q     <= LivesInit;
      score_q     <= 8'd0;
      hop_q       <= 1'b0;
      draw_q      <= 1'b0;
      hop_cnt_q   <= '0;
      death_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      frog_x_q    <= frog_x_d;
      frog_y_q    <= frog_y_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      hop_q       <= hop_d;
      draw_q      <= draw_d;
      hop_cnt_q   <= hop_cnt_d;
      death_cnt_q <= death_cnt_d;
    end
  end

  // Next-state: collision beats moves and cooldown expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StGameOver: if (bus.i_Start) state_d = StPlay;
      StPlay: begin
        if (bus.i_Collide)  state_d = StDead;
        else if (move_ok)   state_d = StHop;
      end
      StHop: begin
        if (bus.i_Collide)  state_d = StDead;
        else if (hop_done)  state_d = StPlay;
      end
      StDead: if (death_done) state_d = (lives_q != 2'd0) ? StPlay : StGameOver;
      default: state_d = StIdle;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    frog_x_d    = frog_x_q;
    frog_y_d    = frog_y_q;
    lives_d     = lives_q;
    score_d     = score_q;
    hop_d       = 1'b0;
    hop_cnt_d   = hop_cnt_q;
    death_cnt_d = death_cnt_q;
    case (state_q)
      StIdle, StGameOver: begin
        if (bus.i_Start) begin
          frog_x_d = XBase;
          frog_y_d = YBase;
          lives_d  = LivesInit;
          score_d  = 8'd0;
        end
      end
      StPlay: begin
        if (bus.i_Collide) begin
          lives_d     = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
          death_cnt_d = '0;
        end else if (move_ok) begin
          hop_d     = 1'b1;
          hop_cnt_d = '0;
          if (goal) begin
            frog_x_d = XBase;
            frog_y_d = YBase;
            score_d  = (score_q == 8'hFF) ? 8'hFF : score_q + 8'd1;
          end else if (up_ok) begin
            frog_y_d = frog_y_q - Step;
          end else if (dn_ok) begin
            frog_y_d = frog_y_q + Step;
          end else if (lt_ok) begin
            frog_x_d = frog_x_q - Step;
          end else begin
            frog_x_d = frog_x_q + Step;
          end
        end
      end
      StHop: begin
        if (bus.i_Collide) begin
          lives_d     = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
          death_cnt_d = '0;
        end else if (!hop_done) begin
          hop_cnt_d = hop_cnt_q + HopW'(1);
        end
      end
      StDead: begin
        if (death_done) begin
          frog_x_d = XBase;
          frog_y_d = YBase;
        end else begin
          death_cnt_d = death_cnt_q + DeathW'(1);
        end
      end
      default: ;
    endcase
    // Sprite visible while playing; blinks on counter bit 3 while dead.
    draw_d = (state_d == StPlay) || (state_d == StHop) ||
             ((state_d == StDead) && !death_cnt_d[3]);
  end

  assign bus.o_Frog_X    = frog_x_q;
  assign bus.o_Frog_Y    = frog_y_q;
  assign bus.o_Draw_Frog = draw_q;
  assign bus.o_State     = state_q;
  assign bus.o_Lives     = lives_q;
  assign bus.o_Score     = score_q;
  assign bus.o_Hop       = hop_q;

endmodule

// File: tb/tb_frog_game_ctrl.sv
// Bench for frog_game_ctrl: directed vector table, hand-written corner
// sequences, then random stimulus against a behavioural game model.
module tb_frog_game_ctrl;

  localparam int TILE = 32;
  localparam int HV = 640;
  localparam int VV = 480;
  localparam int XB = 320;
  localparam int YB = 448;
  localparam int HOPC = 4;
  localparam int DEATHC = 16;
  localparam int NLIVES = 2;

  localparam int S_IDLE = 0;
  localparam int S_PLAY = 1;
  localparam int S_HOP = 2;
  localparam int S_DEAD = 3;
  localparam int S_OVER = 4;

  // Input bundle order: {start, up, dn, lt, rt, collide}
  localparam logic [5:0] I_NONE = 6'b000000;
  localparam logic [5:0] I_ST   = 6'b100000;
  localparam logic [5:0] I_UP   = 6'b010000;
  localparam logic [5:0] I_DN   = 6'b001000;
  localparam logic [5:0] I_LT   = 6'b000100;
  localparam logic [5:0] I_RT   = 6'b000010;
  localparam logic [5:0] I_COL  = 6'b000001;

  logic i_Clk = 1'b0;
  logic i_Rst = 1'b1;
  always #5 i_Clk = ~i_Clk;

  frog_game_ctrl_if bus ();

  frog_game_ctrl #(
    .TILE_SIZE(TILE), .H_VISIBLE_AREA(HV), .V_VISIBLE_AREA(VV),
    .X_BASE(XB), .Y_BASE(YB), .HOP_CYCLES(HOPC), .DEATH_CYCLES(DEATHC), .LIVES(NLIVES)
  ) dut (
    .i_Clk(i_Clk),
    .i_Rst(i_Rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int st, input int x, input int y,
                         input int lives, input int score, input int hop, input int draw);
    chk({tag, ".state"}, 32'(bus.o_State), st);
    chk({tag, ".x"}, 32'(bus.o_Frog_X), x);
    chk({tag, ".y"}, 32'(bus.o_Frog_Y), y);
    chk({tag, ".lives"}, 32'(bus.o_Lives), lives);
    chk({tag, ".score"}, 32'(bus.o_Score), score);
    chk({tag, ".hop"}, 32'(bus.o_Hop), hop);
    chk({tag, ".draw"}, 32'(bus.o_Draw_Frog), draw);
  endtask

  task automatic drive(input logic [5:0] in);
    bus.i_Start   = in[5];
    bus.i_Frog_Up = in[4];
    bus.i_Frog_Dn = in[3];
    bus.i_Frog_Lt = in[2];
    bus.i_Frog_Rt = in[1];
    bus.i_Collide = in[0];
  endtask

  // Apply inputs, clock once, sample on the falling edge.
  task automatic step(input logic [5:0] in);
    drive(in);
    @(posedge i_Clk);
    @(negedge i_Clk);
  endtask

  typedef struct {
    logic [5:0] in;
    int st, x, y, lives, score, hop, draw;
  } vec_t;

  vec_t vecs[13];

  // ---------------- behavioural reference model ----------------
  int m_st, m_x, m_y, m_lives, m_score, m_hop, m_draw, m_hop_age, m_dead_age;

  task automatic model_reset();
    m_st = S_IDLE; m_x = XB; m_y = YB; m_lives = NLIVES; m_score = 0;
    m_hop = 0; m_draw = 0; m_hop_age = 0; m_dead_age = 0;
  endtask

  task automatic model_die();
    if (m_lives > 0) m_lives--;
    m_st = S_DEAD;
    m_dead_age = 0;
  endtask

  task automatic model_step(input logic [5:0] in);
    int nbtn, nx, ny;
    bit ok;
    m_hop = 0;
    case (m_st)
      S_IDLE, S_OVER: if (in[5]) begin
        m_st = S_PLAY; m_lives = NLIVES; m_score = 0; m_x = XB; m_y = YB;
      end
      S_PLAY: begin
        if (in[0]) model_die();
        else begin
          nbtn = int'(in[4]) + int'(in[3]) + int'(in[2]) + int'(in[1]);
          nx = m_x; ny = m_y; ok = 0;
          if (nbtn == 1) begin
            if (in[4])      begin ok = (m_y >= TILE);             ny = m_y - TILE; end
            else if (in[3]) begin ok = (m_y + TILE <= VV - TILE); ny = m_y + TILE; end
            else if (in[2]) begin ok = (m_x >= TILE);             nx = m_x - TILE; end
            else            begin ok = (m_x + TILE <= HV - TILE); nx = m_x + TILE; end
          end
          if (ok) begin
            m_hop = 1; m_st = S_HOP; m_hop_age = 0;
            if (ny == 0) begin
              m_x = XB; m_y = YB;
              if (m_score < 255) m_score++;
            end else begin
              m_x = nx; m_y = ny;
            end
          end
        end
      end
      S_HOP: begin
        if (in[0]) model_die();
        else begin
          m_hop_age++;
          if (m_hop_age == HOPC) m_st = S_PLAY;
        end
      end
      S_DEAD: begin
        m_dead_age++;
        if (m_dead_age == DEATHC) begin
          m_x = XB; m_y = YB;
          m_st = (m_lives != 0) ? S_PLAY : S_OVER;
        end
      end
      default: ;
    endcase
    m_draw = (m_st == S_PLAY || m_st == S_HOP ||
              (m_st == S_DEAD && ((m_dead_age / 8) % 2 == 0))) ? 1 : 0;
  endtask

  initial begin
    logic [5:0] rin;
    int any_hop;
    int r;

    vecs[0]  = '{I_ST,    S_PLAY, 320, 448, 2, 0, 0, 1};
    vecs[1]  = '{I_RT,    S_HOP,  352, 448, 2, 0, 1, 1};
    vecs[2]  = '{I_RT,    S_HOP,  352, 448, 2, 0, 0, 1};
    vecs[3]  = '{I_RT,    S_HOP,  352, 448, 2, 0, 0, 1};
    vecs[4]  = '{I_RT,    S_HOP,  352, 448, 2, 0, 0, 1};
    vecs[5]  = '{I_RT,    S_PLAY, 352, 448, 2, 0, 0, 1};
    vecs[6]  = '{I_RT,    S_HOP,  384, 448, 2, 0, 1, 1};
    vecs[7]  = '{I_NONE,  S_HOP,  384, 448, 2, 0, 0, 1};
    vecs[8]  = '{I_UP | I_LT, S_HOP, 384, 448, 2, 0, 0, 1};
    vecs[9]  = '{I_ST,    S_HOP,  384, 448, 2, 0, 0, 1};
    vecs[10] = '{I_NONE,  S_PLAY, 384, 448, 2, 0, 0, 1};
    vecs[11] = '{I_UP | I_LT, S_PLAY, 384, 448, 2, 0, 0, 1};
    vecs[12] = '{I_COL,   S_DEAD, 384, 448, 1, 0, 0, 1};

    // Reset values
    drive(I_NONE);
    repeat (2) @(negedge i_Clk);
    chk_all("reset", S_IDLE, 320, 448, 2, 0, 0, 0);
    i_Rst = 1'b0;
    step(I_UP);
    chk_all("idle_no_start", S_IDLE, 320, 448, 2, 0, 0, 0);

    // Vector table: start, held right auto-repeat, cooldown, collision
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].in);
      chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].x, vecs[i].y,
              vecs[i].lives, vecs[i].score, vecs[i].hop, vecs[i].draw);
    end

    // Death blink and respawn; start/buttons ignored while dead
    for (int k = 1; k <= 16; k++) begin
      step((k < 16) ? (I_ST | I_UP) : I_NONE);
      if (k == 7)  chk("blink7", 32'(bus.o_Draw_Frog), 1);
      if (k == 8)  chk("blink8", 32'(bus.o_Draw_Frog), 0);
      if (k == 15) chk_all("dead15", S_DEAD, 384, 448, 1, 0, 0, 0);
    end
    chk_all("respawn", S_PLAY, 320, 448, 1, 0, 0, 1);

    // Two buttons together never hop
    any_hop = 0;
    for (int i = 0; i < 20; i++) begin
      step(I_UP | I_LT);
      if (bus.o_Hop) any_hop++;
    end
    chk("multi_btn_hops", any_hop, 0);
    chk_all("multi_btn", S_PLAY, 320, 448, 1, 0, 0, 1);

    // 14 up hops: the last one reaches row 0 and scores
    for (int i = 0; i < 66; i++) begin
      step(I_UP);
      if (i == 60) begin
        chk("up13.y", 32'(bus.o_Frog_Y), 32);
        chk("up13.hop", 32'(bus.o_Hop), 1);
      end
    end
    chk_all("goal", S_HOP, 320, 448, 1, 1, 1, 1);
    repeat (4) step(I_NONE);

    // Walk right to the edge, then the right move is blocked
    for (int i = 0; i <= 45; i++) begin
      step(I_RT);
      if (i == 44) chk("at_edge.x", 32'(bus.o_Frog_X), 608);
    end
    chk_all("rt_blocked", S_PLAY, 608, 448, 1, 1, 0, 1);
    step(I_DN);
    chk_all("dn_blocked", S_PLAY, 608, 448, 1, 1, 0, 1);

    // Collision during HOP, last life lost, game over, restart
    step(I_LT);
    chk_all("hop_left", S_HOP, 576, 448, 1, 1, 1, 1);
    step(I_COL);
    chk_all("die_in_hop", S_DEAD, 576, 448, 0, 1, 0, 1);
    for (int k = 1; k <= 16; k++) step((k < 16) ? I_ST : I_NONE);
    chk_all("gameover", S_OVER, 320, 448, 0, 1, 0, 0);
    step(I_RT);
    chk_all("gameover_btn", S_OVER, 320, 448, 0, 1, 0, 0);
    step(I_ST);
    chk_all("restart", S_PLAY, 320, 448, 2, 0, 0, 1);

    // Asynchronous reset mid-HOP at X=384
    step(I_RT);
    repeat (4) step(I_RT);
    step(I_RT);
    chk_all("pre_rst", S_HOP, 384, 448, 2, 0, 1, 1);
    step(I_NONE);
    #2 i_Rst = 1'b1;
    #1 chk_all("async_rst", S_IDLE, 320, 448, 2, 0, 0, 0);
    @(negedge i_Clk);
    i_Rst = 1'b0;
    step(I_NONE);
    chk_all("post_rst", S_IDLE, 320, 448, 2, 0, 0, 0);

    // Random play against the behavioural model
    i_Rst = 1'b1;
    @(negedge i_Clk);
    i_Rst = 1'b0;
    model_reset();
    for (int n = 0; n < 4000; n++) begin
      rin = '0;
      rin[5] = ($urandom_range(0, 19) == 0);
      rin[0] = ($urandom_range(0, 24) == 0);
      r = $urandom_range(0, 9);
      if (r <= 5)      rin[4 - (r % 4)] = 1'b1;
      else if (r >= 7) rin[4:1] = 4'($urandom_range(0, 15));
      step(rin);
      model_step(rin);
      chk_all("rnd", m_st, m_x, m_y, m_lives, m_score, m_hop, m_draw);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frog_game_ctrl.md
Name: frog_game_ctrl

Overview:
- Game-level sequencer that owns the frog position register and decides when a button press becomes a hop.
- Adds per-hop cooldown (auto-repeat while held), collision-driven death with a respawn timer, a lives counter, goal detection with scoring, and start/game-over control.
- Sits between the debounced board buttons and the VGA sprite renderer; its position outputs feed the frog draw logic directly.

Parameters:
- TILE_SIZE, 32, hop distance in pixels; positions are always multiples of it.
- H_VISIBLE_AREA, 640, visible width in pixels.
- V_VISIBLE_AREA, 480, visible height in pixels.
- X_BASE, 320, respawn X.
- Y_BASE, 448, respawn Y (bottom row).
- HOP_CYCLES, 2500000, cooldown cycles after each accepted hop (≥1).
- DEATH_CYCLES, 12500000, cycles spent in DEAD before respawn (≥1).
- LIVES, 3, lives at game start (1..3).

Ports:
- i_Clk  in  1  system clock
- i_Rst  in  1  asynchronous active-high reset
- i_Start  in  1  level; starts or restarts a game
- i_Frog_Up  in  1  debounced button
- i_Frog_Dn  in  1  debounced button
- i_Frog_Lt  in  1  debounced button
- i_Frog_Rt  in  1  debounced button
- i_Collide  in  1  hazard overlap from the renderer, level
- o_Frog_X  out  10  frog X in pixels
- o_Frog_Y  out  10  frog Y in pixels
- o_Draw_Frog  out  1  renderer enable
- o_State  out  3  IDLE=0, PLAY=1, HOP=2, DEAD=3, GAMEOVER=4
- o_Lives  out  2  remaining lives
- o_Score  out  8  goals reached, saturating at 255
- o_Hop  out  1  one-cycle pulse on each accepted hop

Behaviour:
- Reset, and also any time i_Rst is asserted mid-operation:
  - X=X_BASE, Y=Y_BASE, state IDLE, lives=LIVES, score=0.
  - o_Hop=0, o_Draw_Frog=0, counters cleared.
- All outputs are registered and update one cycle after the qualifying input is sampled.
- o_Draw_Frog = 1 in PLAY, HOP and DEAD-with-counter-bit-clear; 0 in IDLE and GAMEOVER. DEAD blinks using bit 3 of the death counter.
- IDLE: i_Start=1 → PLAY. Lives, score and position reload.
- PLAY:
  - Priority: i_Collide > move.
  - A move is valid only if exactly one direction input is high (one-hot; 0 or ≥2 high means no move).
  - Bounds:
    - Up allowed if Y ≥ TILE_SIZE.
    - Dn allowed if Y + TILE_SIZE ≤ V_VISIBLE_AREA − TILE_SIZE.
    - Lt allowed if X ≥ TILE_SIZE.
    - Rt allowed if X + TILE_SIZE ≤ H_VISIBLE_AREA − TILE_SIZE.
  - Comparisons use 11-bit arithmetic (no wrap).
  - Blocked move: no position change, no o_Hop, stay in PLAY.
  - Accepted move: position ± TILE_SIZE, o_Hop=1 for one cycle, cooldown counter=0, → HOP.
  - Goal: an accepted Up whose new Y is 0 instead sets X=X_BASE, Y=Y_BASE and score+1 (saturating). o_Hop still pulses; → HOP.
- HOP:
  - Counter increments each cycle; at HOP_CYCLES−1 → PLAY.
  - A still-held button then hops again on the next PLAY cycle (auto-repeat period HOP_CYCLES+1).
  - i_Collide=1 in HOP → DEAD immediately; collision wins over cooldown expiry in the same cycle.
- Entering DEAD from PLAY or HOP: lives−1 and death counter=0. Inputs other than i_Rst are ignored while in DEAD.
- DEAD: at DEATH_CYCLES−1, X=X_BASE and Y=Y_BASE. Then → PLAY if lives≠0, else → GAMEOVER.
- GAMEOVER: position frozen at base. i_Start=1 → PLAY with lives=LIVES and score=0.
- i_Start is ignored in PLAY, HOP and DEAD.
- Direction buttons are ignored outside PLAY.

Test Plan:
- Setup: TILE=32, HOP_CYCLES=4, DEATH_CYCLES=16, LIVES=2.
- Reset, pulse i_Start, hold i_Frog_Rt → Y stays 448, X=352 one cycle later with o_Hop pulse; next hop X=384 exactly 5 cycles after the first.
- From base, hold Up and Lt together for 20 cycles → no o_Hop, X=320, Y=448; then Up alone for 14 hops → on the Y-to-0 hop, Y=448, X=320, score=1, o_Hop pulsed.
- At X=608 press Rt → blocked, no o_Hop, state stays PLAY; at Y=448 press Dn → blocked.
- Assert i_Collide in HOP → state DEAD next cycle, lives=1, o_Draw_Frog toggles every 8 cycles; after 16 cycles position=(320,448), state PLAY.
- Second collision → lives=0, after 16 cycles state GAMEOVER, o_Draw_Frog=0; i_Start → PLAY, lives=2, score=0.
- Assert i_Rst asynchronously mid-HOP at X=384 → outputs return to reset values within the reset cycle, state IDLE.
